// File: rtl/cs_y_packer.sv
// Buffers the CS block's Y results in a small FIFO and packs them MSB-first
// into a dense stream of OW-bit words with a valid/ready handshake.
module cs_y_packer #(
  parameter int YW    = 10,
  parameter int OW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [YW-1:0] y_in,
  input  logic          y_valid,
  input  logic          flush,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overflow,
  output logic          busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int ACCW = OW + YW;
  localparam int CW   = $clog2(ACCW + 1);

  logic [YW-1:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [ACCW-1:0] acc, acc_a, acc_n, word_al;
  logic [CW-1:0]   cnt, cnt_a, cnt_n;
  logic            flush_pend;

  logic fifo_empty, fifo_full, out_free, emit, pop, push, flush_done;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign out_free   = !out_valid || out_ready;
  assign emit       = out_free && (cnt >= CW'(OW));
  assign flush_done = flush_pend && fifo_empty && (cnt < CW'(OW)) && out_free;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_a   = acc;
    cnt_a   = cnt;
    if (emit) begin
      acc_a = acc << OW;
      cnt_a = cnt - CW'(OW);
    end
    pop     = !fifo_empty && (cnt_a <= CW'(OW));
    push    = y_valid && (!fifo_full || pop);
    // New Y lands directly below the bits still waiting in the accumulator.
    word_al = {mem[rd_ptr[AW-1:0]], {OW{1'b0}}} >> cnt_a;
    acc_n   = acc_a;
    cnt_n   = cnt_a;
    if (pop) begin
      acc_n = acc_a | word_al;
      cnt_n = cnt_a + CW'(YW);
    end else if (flush_done) begin
      acc_n = '0;
      cnt_n = '0;
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= y_in;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      acc        <= '0;
      cnt        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      acc    <= acc_n;
      cnt    <= cnt_n;
      // Flush padding relies on bits below cnt always being zero in acc.
      if (emit || (flush_done && cnt != '0)) begin
        out_data  <= acc[ACCW-1 -: OW];
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (y_valid && fifo_full && !pop) overflow <= 1'b1;
      flush_pend <= flush_pend ? !flush_done : flush;
    end
  end

  assign busy = !fifo_empty || (cnt != '0) || out_valid || flush_pend;

endmodule

// File: tb/tb_cs_y_packer.sv
// Self-checking bench for cs_y_packer: a bit-queue model checked every cycle,
// plus hand-computed word sequences for the directed cases.
module tb_cs_y_packer;

  localparam int YW    = 10;
  localparam int OW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [YW-1:0] y_in;
  logic          y_valid;
  logic          flush;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 0;

  cs_y_packer #(.YW(YW), .OW(OW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the accumulator is a plain queue of pending bits, oldest first.
  bit            q_bits[$];
  logic [YW-1:0] m_fifo[$];
  logic [OW-1:0] m_out;
  bit            m_ov, m_fp, m_ovf;
  bit            ov0, fp0, free, pop, done;
  int            fsz, bsz;
  logic [YW-1:0] w;
  logic [OW-1:0] dut_log[$];

  always @(posedge clk) begin
    if (reset && out_valid && out_ready) dut_log.push_back(out_data);
    if (!reset) begin
      q_bits.delete();
      m_fifo.delete();
      m_out = '0;
      m_ov  = 0;
      m_fp  = 0;
      m_ovf = 0;
    end else begin
      ov0  = m_ov;
      fp0  = m_fp;
      fsz  = m_fifo.size();
      bsz  = q_bits.size();
      free = !ov0 || out_ready;
      if (free && bsz >= OW) begin
        for (int i = 0; i < OW; i++) m_out[OW-1-i] = q_bits.pop_front();
        m_ov = 1;
      end else if (ov0 && out_ready) begin
        m_ov = 0;
      end
      done = fp0 && fsz == 0 && bsz < OW && free;
      if (done && bsz > 0) begin
        m_out = '0;
        for (int i = 0; i < bsz; i++) m_out[OW-1-i] = q_bits.pop_front();
        m_ov = 1;
      end
      pop = fsz > 0 && q_bits.size() <= OW;
      if (pop) begin
        w = m_fifo.pop_front();
        for (int i = YW-1; i >= 0; i--) q_bits.push_back(w[i]);
      end
      if (y_valid) begin
        if (fsz < DEPTH || pop) m_fifo.push_back(y_in);
        else m_ovf = 1;
      end
      m_fp = fp0 ? !done : flush;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      if (m_ov) check("out_data", {16'd0, out_data}, {16'd0, m_out});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("busy", {31'd0, busy},
            {31'd0, (m_fifo.size() > 0 || q_bits.size() > 0 || m_ov || m_fp)});
    end
  end

  task automatic send(input logic [YW-1:0] v);
    y_valid = 1'b1;
    y_in    = v;
    @(negedge clk);
    y_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [OW-1:0] exp8_001 [5] = '{16'h0040, 16'h1004, 16'h0100, 16'h4010, 16'h0401};
  bit            sent_bits[$];
  logic [OW-1:0] held;
  logic [OW-1:0] ew;

  initial begin
    reset = 1'b0; y_in = '0; y_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset  = 1'b1;
    cmp_en = 1;

    // Eight all-ones results: exactly five full words, nothing left over.
    dut_log.delete();
    for (int i = 0; i < 8; i++) send(10'h3FF);
    wait_idle("ones_idle");
    check("ones_count", dut_log.size(), 5);
    foreach (dut_log[i]) check("ones_word", {16'd0, dut_log[i]}, 32'h0000FFFF);

    dut_log.delete();
    for (int i = 0; i < 8; i++) send(10'h001);
    wait_idle("lsb_idle");
    check("lsb_count", dut_log.size(), 5);
    foreach (dut_log[i]) if (i < 5) check("lsb_word", {16'd0, dut_log[i]}, {16'd0, exp8_001[i]});

    dut_log.delete();
    send(10'h2AB);
    pulse_flush();
    wait_idle("flush_idle");
    check("flush_count", dut_log.size(), 1);
    if (dut_log.size() > 0) check("flush_word", {16'd0, dut_log[0]}, 32'h0000AAC0);

    // Stalled consumer: the ninth word is the first that finds the FIFO full.
    do_reset();
    dut_log.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      y_valid = 1'b1;
      y_in    = (k < 8) ? 10'h3FF : 10'h155;
      @(negedge clk);
      check($sformatf("ovf_step%0d", k), {31'd0, overflow}, {31'd0, (k >= 8)});
    end
    y_valid = 1'b0;
    held = out_data;
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    repeat (3) @(negedge clk);
    check("stall_data", {16'd0, out_data}, {16'd0, held});
    out_ready = 1'b1;
    pulse_flush();
    wait_idle("stall_idle");
    check("stall_count", dut_log.size(), 5);
    foreach (dut_log[i]) check("stall_word", {16'd0, dut_log[i]}, 32'h0000FFFF);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset while a word is waiting for the consumer.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(10'h3FF);
    @(negedge clk);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    out_ready = 1'b1;
    dut_log.delete();
    send(10'h2AB);
    pulse_flush();
    wait_idle("post_rst_idle");
    check("post_rst_count", dut_log.size(), 1);
    if (dut_log.size() > 0) check("post_rst_word", {16'd0, dut_log[0]}, 32'h0000AAC0);

    // Long random stream, unpacked end to end against what was sent.
    dut_log.delete();
    sent_bits.delete();
    for (int n = 0; n < 2000; ) begin
      out_ready = ($urandom_range(0, 9) < 8);
      y_valid   = $urandom_range(0, 1);
      y_in      = YW'($urandom);
      if (y_valid) begin
        for (int b = YW-1; b >= 0; b--) sent_bits.push_back(y_in[b]);
        n++;
      end
      @(negedge clk);
    end
    y_valid   = 1'b0;
    out_ready = 1'b1;
    pulse_flush();
    wait_idle("rand_idle");
    check("rand_overflow", {31'd0, overflow}, 32'd0);
    check("rand_count", dut_log.size(), (sent_bits.size() + OW - 1) / OW);
    foreach (dut_log[i]) begin
      ew = '0;
      for (int b = 0; b < OW; b++)
        if (i*OW + b < sent_bits.size()) ew[OW-1-b] = sent_bits[i*OW + b];
      check($sformatf("rand_word%0d", i), {16'd0, dut_log[i]}, {16'd0, ew});
    end

    @(negedge clk);
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
